// File: rtl/latch_bank_write_sched.sv
// rtl/latch_bank_write_sched.sv - write/clear sequencer for a latch bank (optional LATCH_BANK_CLEAR_ON_RESET_EN)
module latch_bank_write_sched #(
    parameter int NWORDS    = 8,
    parameter int AW        = 3,
    parameter int DW        = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int RECOV_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AW-1:0]     req_addr,
    input  logic [DW-1:0]     req_data,
    input  logic              clr_req,
    output logic              clr_ack,
    output logic              addr_err,
    output logic              busy,
    output logic [DW-1:0]     lat_d,
    output logic [NWORDS-1:0] lat_gaten,
    output logic              lat_resetb
);

    localparam int CW = 8;
    localparam logic [CW-1:0] SETUP_LAST = (SETUP_CYC > 0) ? CW'(SETUP_CYC - 1) : '0;
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = (HOLD_CYC > 0) ? CW'(HOLD_CYC - 1) : '0;
    localparam logic [CW-1:0] RECOV_LAST = CW'(RECOV_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CLEAR = 3'd4,
        RECOV = 3'd5
    } state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [AW-1:0]       addr_q, addr_n;
    logic                accept;
    logic                pending_clr;
    logic [NWORDS-1:0]   gate_n;

`ifdef LATCH_BANK_CLEAR_ON_RESET_EN
    // Arm a bank clear during reset; it is consumed the first time IDLE launches it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_clr <= 1'b1;
        end else if (state == IDLE) begin
            pending_clr <= 1'b0;
        end
    end
`else
    assign pending_clr = 1'b0;
`endif

    // Handshake and status; reset forces both low without waiting for an edge.
    assign req_ready = !reset && (state == IDLE) && !clr_req && !pending_clr;
    assign busy      = !reset && ((state != IDLE) || pending_clr);

    // Next-state, phase counter and request capture.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        addr_n  = addr_q;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (clr_req || pending_clr) begin
                    state_n = CLEAR;
                end else if (req_valid) begin
                    accept  = 1'b1;
                    addr_n  = req_addr;
                    state_n = (SETUP_CYC > 0) ? SETUP : PULSE;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_n = PULSE;
                    cnt_n   = '0;
                end
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_n = (HOLD_CYC > 0) ? HOLD : IDLE;
                    cnt_n   = '0;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            CLEAR: begin
                if (cnt == PULSE_LAST) begin
                    state_n = RECOV;
                    cnt_n   = '0;
                end
            end
            RECOV: begin
                if (cnt == RECOV_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Gate vector for the coming cycle: only the addressed, in-range word opens.
    always_comb begin
        gate_n = '1;
        for (int i = 0; i < NWORDS; i++) begin
            gate_n[i] = !((state_n == PULSE) && (int'(addr_n) == i));
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr_q <= addr_n;
        end
    end

    // Array-facing outputs are registered from next-state so they never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_d      <= '0;
            lat_gaten  <= '1;
            lat_resetb <= 1'b1;
            clr_ack    <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_d <= req_data;
            end
            lat_gaten  <= gate_n;
            lat_resetb <= (state_n != CLEAR);
            clr_ack    <= (state_n == RECOV) && (cnt_n == RECOV_LAST);
            addr_err   <= (state_n == PULSE) && (cnt_n == '0) && (int'(addr_n) >= NWORDS);
        end
    end

endmodule

// File: tb/tb_latch_bank_write_sched.sv
// tb/tb_latch_bank_write_sched.sv - scoreboard bench for latch_bank_write_sched
module tb_latch_bank_write_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, req_valid, clr_req;
    logic [3:0] req_addr;
    logic [7:0] req_data;
    logic       req_ready, clr_ack, addr_err, busy, lat_resetb;
    logic [7:0] lat_d, lat_gaten;

    logic       v2;
    logic [2:0] a2;
    logic [7:0] d2;
    logic       r2, ack2, err2, busy2, rb2;
    logic [7:0] ld2, g2;

    int total = 0;
    int bad   = 0;

    localparam int K_W = 0;
    localparam int K_E = 1;
    localparam int K_C = 2;

    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;
    ev_t exp_q[$];

    latch_bank_write_sched #(.NWORDS(8), .AW(4), .DW(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .clr_req(clr_req), .clr_ack(clr_ack),
        .addr_err(addr_err), .busy(busy), .lat_d(lat_d), .lat_gaten(lat_gaten),
        .lat_resetb(lat_resetb)
    );

    latch_bank_write_sched #(.NWORDS(8), .AW(3), .DW(8), .SETUP_CYC(0), .PULSE_CYC(1),
                             .HOLD_CYC(0), .RECOV_CYC(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(v2), .req_ready(r2),
        .req_addr(a2), .req_data(d2), .clr_req(1'b0), .clr_ack(ack2),
        .addr_err(err2), .busy(busy2), .lat_d(ld2), .lat_gaten(g2),
        .lat_resetb(rb2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int a, input int d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input int k, input int a, input int d);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected kind=%0d addr=%0d data=%0h required=none", k, a, d);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", k, e.kind);
            chk("sb_addr", a, e.addr);
            chk("sb_data", d, e.data);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Monitor for the main instance: invariants plus scoreboard pops on output events.
    logic [7:0] prev_g = 8'hFF;
    logic [7:0] prev_d = 8'h00;
    int plen = 0;
    int mon_zeros, mon_idx;
    always @(negedge clk) begin
        if (reset) begin
            plen = 0;
        end else begin
            mon_zeros = 0;
            mon_idx   = 0;
            for (int i = 0; i < 8; i++) begin
                if (!lat_gaten[i]) begin
                    mon_zeros++;
                    mon_idx = i;
                end
            end
            chk("onehot_low", mon_zeros <= 1, 1);
            if (mon_zeros != 0) begin
                chk("gate_vs_resetb", lat_resetb, 1);
                chk("d_stable", lat_d, prev_d);
                plen++;
                if (prev_g == 8'hFF) sb_pop(K_W, mon_idx, lat_d);
            end else if (plen != 0) begin
                chk("pulse_len", plen, 2);
                plen = 0;
            end
            if (addr_err) sb_pop(K_E, 0, 0);
            if (clr_ack) sb_pop(K_C, 0, 0);
        end
        prev_g = lat_gaten;
        prev_d = lat_d;
    end

    // Invariants for the zero-setup/zero-hold instance.
    logic [7:0] prev_g2 = 8'hFF;
    logic [7:0] prev_d2 = 8'h00;
    int z2;
    always @(negedge clk) begin
        if (!reset) begin
            z2 = 0;
            for (int i = 0; i < 8; i++) if (!g2[i]) z2++;
            chk("onehot_low2", z2 <= 1, 1);
            if (prev_g2 != 8'hFF) chk("d_stable2", ld2, prev_d2);
        end
        prev_g2 = g2;
        prev_d2 = ld2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; clr_req = 1'b0; req_addr = '0; req_data = '0;
        v2 = 1'b0; a2 = '0; d2 = '0;
        repeat (3) step();
        chk("rst_ready", req_ready, 0);
        chk("rst_gaten", lat_gaten, 8'hFF);
        chk("rst_resetb", lat_resetb, 1);
        chk("rst_d", lat_d, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", clr_ack, 0);
        chk("rst_err", addr_err, 0);
        reset = 1'b0;
        #1;
`ifdef LATCH_BANK_CLEAR_ON_RESET_EN
        chk("boot_ready", req_ready, 0);
        chk("boot_busy", busy, 1);
        push(K_C, 0, 0);
        for (int i = 0; i < 20 && !req_ready; i++) step();
        chk("boot_ready_after", req_ready, 1);
`else
        chk("boot_ready", req_ready, 1);
        chk("boot_busy", busy, 0);
`endif

        // Single write addr 3 / 0xA5
        req_valid = 1'b1; req_addr = 4'd3; req_data = 8'hA5; push(K_W, 3, 'hA5);
        step(); req_valid = 1'b0;
        chk("w1_t1_d", lat_d, 8'hA5);
        chk("w1_t1_gate", lat_gaten, 8'hFF);
        chk("w1_t1_ready", req_ready, 0);
        chk("w1_t1_busy", busy, 1);
        step(); chk("w1_t2_gate", lat_gaten, 8'hF7);
        step(); chk("w1_t3_gate", lat_gaten, 8'hF7);
        step(); chk("w1_t4_gate", lat_gaten, 8'hFF); chk("w1_t4_ready", req_ready, 0);
        chk("w1_t4_d", lat_d, 8'hA5);
        step(); chk("w1_t5_ready", req_ready, 1);

        // Back-to-back writes with valid held
        req_valid = 1'b1; req_addr = 4'd0; req_data = 8'h11; push(K_W, 0, 'h11);
        step();
        req_addr = 4'd7; req_data = 8'h22; push(K_W, 7, 'h22);
        chk("b2b_t1_d", lat_d, 8'h11);
        for (int t = 2; t <= 4; t++) begin
            step();
            chk("b2b_hold_d", lat_d, 8'h11);
            chk("b2b_not_ready", req_ready, 0);
        end
        step(); chk("b2b_t5_ready", req_ready, 1);
        step(); req_valid = 1'b0; chk("b2b_t6_d", lat_d, 8'h22);
        step(); chk("b2b_t7_gate", lat_gaten, 8'h7F);
        step(); chk("b2b_t8_gate", lat_gaten, 8'h7F);
        step(); chk("b2b_t9_gate", lat_gaten, 8'hFF);
        step(); chk("b2b_t10_ready", req_ready, 1);

        // Clear and write together: clear wins
        clr_req = 1'b1; req_valid = 1'b1; req_addr = 4'd5; req_data = 8'h33;
        #1 chk("clr_blocks_ready", req_ready, 0);
        push(K_C, 0, 0); push(K_W, 5, 'h33);
        step(); clr_req = 1'b0;
        chk("clr_c1_resetb", lat_resetb, 0); chk("clr_c1_gate", lat_gaten, 8'hFF);
        chk("clr_c1_ready", req_ready, 0);
        step(); chk("clr_c2_resetb", lat_resetb, 0);
        step(); chk("clr_c3_resetb", lat_resetb, 1); chk("clr_c3_ack", clr_ack, 0);
        chk("clr_c3_ready", req_ready, 0);
        step(); chk("clr_c4_ack", clr_ack, 1); chk("clr_c4_ready", req_ready, 0);
        step(); chk("clr_c5_ack", clr_ack, 0); chk("clr_c5_ready", req_ready, 1);
        step(); req_valid = 1'b0; chk("clr_w_d", lat_d, 8'h33);
        step(); chk("clr_w_gate", lat_gaten, 8'hDF);
        repeat (3) step();
        chk("clr_w_ready", req_ready, 1);

        // Out-of-range address
        req_valid = 1'b1; req_addr = 4'd9; req_data = 8'h66; push(K_E, 0, 0);
        step(); req_valid = 1'b0; chk("err_t1", addr_err, 0);
        step(); chk("err_t2", addr_err, 1); chk("err_t2_gate", lat_gaten, 8'hFF);
        step(); chk("err_t3", addr_err, 0); chk("err_t3_gate", lat_gaten, 8'hFF);
        step(); chk("err_t4_ready", req_ready, 0);
        step(); chk("err_t5_ready", req_ready, 1);

        // Reset during a gate pulse
        req_valid = 1'b1; req_addr = 4'd2; req_data = 8'h44; push(K_W, 2, 'h44);
        step(); req_valid = 1'b0;
        step(); chk("mid_gate", lat_gaten, 8'hFB);
        reset = 1'b1;
        step();
        chk("mid_rst_gate", lat_gaten, 8'hFF); chk("mid_rst_resetb", lat_resetb, 1);
        chk("mid_rst_busy", busy, 0); chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_ack", clr_ack, 0); chk("mid_rst_err", addr_err, 0);
        step(); reset = 1'b0; #1;
`ifdef LATCH_BANK_CLEAR_ON_RESET_EN
        chk("mid_rel_ready", req_ready, 0);
        chk("mid_rel_busy", busy, 1);
        push(K_C, 0, 0);
        begin
            int rlow = 0;
            for (int i = 0; i < 20 && !req_ready; i++) begin
                step();
                if (!lat_resetb) rlow++;
                if (!req_ready && clr_ack) chk("mid_ready_at_ack", req_ready, 0);
            end
            chk("mid_resetb_len", rlow, 2);
        end
        chk("mid_ready_after", req_ready, 1);
`else
        chk("mid_rel_ready", req_ready, 1);
        chk("mid_rel_busy", busy, 0);
        chk("mid_rel_d", lat_d, 0);
`endif

        // Zero setup / zero hold / one-cycle pulse instance
        for (int i = 0; i < 20 && !r2; i++) step();
        chk("z_ready0", r2, 1);
        v2 = 1'b1; a2 = 3'd4; d2 = 8'h5A;
        step(); a2 = 3'd1; d2 = 8'hC3;
        chk("z_t1_gate", g2, 8'hEF); chk("z_t1_d", ld2, 8'h5A); chk("z_t1_ready", r2, 0);
        step(); chk("z_t2_gate", g2, 8'hFF); chk("z_t2_ready", r2, 1);
        step(); v2 = 1'b0; chk("z_t3_gate", g2, 8'hFD); chk("z_t3_d", ld2, 8'hC3);
        step(); chk("z_t4_gate", g2, 8'hFF); chk("z_t4_ready", r2, 1);

        repeat (3) step();
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/latch_bank_write_sched.md
Name: latch_bank_write_sched

Overview:
- Write/clear sequencer for a bank of NWORDS x DW active-low-gate, active-low-reset latches (dlrtn-style cells).
- Serialises write requests into glitch-free, registered gate pulses with guaranteed data setup and hold around each pulse.
- Generates bank-wide reset pulses with a recovery gap before the next gate.
- Sits between the register-file front end and the latch array; it is the only driver of the array's GATEN, RESETB and D nets.

Parameters:
- NWORDS, 8, number of latch words; one GATEN line each.
- AW, 3, address width; must satisfy 2^AW >= NWORDS.
- DW, 8, data width per word.
- SETUP_CYC, 1, cycles LAT_D is stable before the gate opens; 0 is legal.
- PULSE_CYC, 2, cycles a gate (or RESETB) is held low; must be >= 1.
- HOLD_CYC, 1, cycles LAT_D is held after the gate closes; 0 is legal.
- RECOV_CYC, 2, cycles after RESETB rises before any gate may open; must be >= 1.

Ports:
- CLK  input  1  clock.
- RESET  input  1  synchronous, active-high reset.
- REQ_VALID  input  1  write request valid.
- REQ_READY  output  1  request accepted when VALID && READY.
- REQ_ADDR  input  AW  target word.
- REQ_DATA  input  DW  write data.
- CLR_REQ  input  1  level request to clear the whole bank.
- CLR_ACK  output  1  one-cycle pulse when the clear (including recovery) completes.
- ADDR_ERR  output  1  one-cycle pulse: an accepted request had REQ_ADDR >= NWORDS.
- BUSY  output  1  high whenever state != IDLE.
- LAT_D  output  DW  data bus to all latch D pins.
- LAT_GATEN  output  NWORDS  per-word gate, active-low.
- LAT_RESETB  output  1  bank reset, active-low.

Behaviour:
- All outputs are driven from flops; no combinational path from inputs to LAT_GATEN, LAT_RESETB or LAT_D.
- Values during and after RESET:
  - LAT_GATEN = all ones; LAT_RESETB = 1; LAT_D = 0.
  - REQ_READY = 0 while RESET is high, 1 in the first cycle after it falls.
  - CLR_ACK = 0, ADDR_ERR = 0, BUSY = 0; state = IDLE; counter = 0.
- States: IDLE, SETUP, PULSE, HOLD, CLEAR, RECOV.
- IDLE:
  - REQ_READY = 1 only in IDLE, and only when CLR_REQ = 0.
  - If CLR_REQ = 1, go to CLEAR; clear has priority over a simultaneous REQ_VALID, which is not accepted.
  - Else on VALID && READY: capture addr/data, load LAT_D, go to SETUP (or to PULSE if SETUP_CYC = 0).
- SETUP: LAT_D held, gates closed, for SETUP_CYC cycles, then PULSE.
- PULSE:
  - LAT_GATEN[addr] = 0 for exactly PULSE_CYC cycles; all other bits stay 1.
  - If addr >= NWORDS, no bit goes low, and ADDR_ERR pulses in the first PULSE cycle.
  - Then HOLD (or IDLE if HOLD_CYC = 0).
- HOLD: gates all 1, LAT_D unchanged, for HOLD_CYC cycles, then IDLE. LAT_D retains its last value in IDLE.
- Write timing, with acceptance at edge T0:
  - LAT_D is valid from T0+1.
  - Gate is low during cycles T0+1+SETUP_CYC .. T0+SETUP_CYC+PULSE_CYC.
  - REQ_READY returns at T0+1+SETUP_CYC+PULSE_CYC+HOLD_CYC.
  - With defaults: D at T1, gate low T2–T3, hold T4, READY at T5; back-to-back throughput is one write per 5 cycles.
- CLEAR: LAT_RESETB = 0 for PULSE_CYC cycles, all gates 1, then RECOV.
- RECOV:
  - LAT_RESETB = 1, gates all 1, for RECOV_CYC cycles.
  - CLR_ACK pulses in the last RECOV cycle; then IDLE.
  - CLR_REQ is re-sampled only in IDLE, so a CLR_REQ still high re-enters CLEAR.
- Invariants:
  - At most one LAT_GATEN bit is 0 in any cycle.
  - LAT_GATEN is never 0 while LAT_RESETB is 0, or within RECOV.
  - LAT_D never changes while any gate is 0.
- RESET mid-operation: on the next edge, LAT_GATEN goes to all ones and LAT_RESETB to 1; the in-flight write or clear is abandoned with no ACK or ERR.

Optional Feature:
- Macro: LATCH_BANK_CLEAR_ON_RESET_EN.
- Defined:
  - After RESET falls, the FSM enters CLEAR automatically, running the full CLEAR + RECOV sequence.
  - REQ_READY stays 0 and BUSY = 1 until that sequence finishes.
  - CLR_ACK still pulses.
- Undefined: the FSM leaves reset in IDLE with REQ_READY = 1; latch contents are unspecified until software issues CLR_REQ.

Test Plan:
- Reset, then a write at T0 of addr=3, data=0xA5 (defaults) → LAT_D=0xA5 from T1; LAT_GATEN=8'hF7 at T2–T3, 8'hFF otherwise; REQ_READY=1 again at T5.
- Back-to-back writes (addr 0, 0x11) then (addr 7, 0x22) with VALID held high → second accepted at T5; LAT_D stays 0x11 through T4; GATEN bit7 low at T7–T8.
- CLR_REQ and REQ_VALID asserted together in IDLE → LAT_RESETB low 2 cycles, then 2 RECOV cycles; CLR_ACK pulses once; the request is accepted only afterwards.
- Write to addr=9 with NWORDS=8, AW=4 → ADDR_ERR single-cycle pulse; LAT_GATEN stays all ones; READY returns at T5.
- RESET asserted during PULSE → next edge LAT_GATEN=all ones, BUSY=0, no ACK/ERR. Same test with LATCH_BANK_CLEAR_ON_RESET_EN defined → RESETB pulse occurs and READY is held 0 until CLR_ACK.
- SETUP_CYC=0, HOLD_CYC=0, PULSE_CYC=1 → gate low at T1 only, READY at T2; a checker confirms the one-hot-low and D-stable invariants every cycle.
